farm_sensor_conditioner: RTL
============================

// Module: farm_sensor_conditioner
// PURPOSE
//  Upstream stage of the highway/farm traffic-light controller. Takes the raw farm-road
//  vehicle-loop sensor and produces the clean, latched request (car_req) that drives the
//  controller's C input. Synchronises, debounces, and latches a request until served.
//  Served means the controller shows farm-road green, signalled by the farm_green input.
// PARAMETERS
//  SYNC_STAGES   2    synchroniser flops on sensor_raw (>=2)
//  DEB_CYCLES    4    consecutive disagreeing samples required to flip debounced level (>=1)
//  STUCK_CYCLES  64   continuous-high cycles declaring sensor stuck (only with SENSOR_STUCK_DETECT_EN)
//  CNT_W         $clog2(STUCK_CYCLES+1)  shared counter width (derived; do not override)
// PORTS
//  clk           in   1  single clock for all logic
//  rst           in   1  synchronous, active-high reset
//  sensor_raw    in   1  asynchronous loop-detector output, 1 = vehicle present
//  farm_green    in   1  1 while the controller drives farm-road green (decoded from light_farm)
//  car_req       out  1  registered request to controller C input
//  sensor_db     out  1  debounced sensor level (observability)
//  sensor_fault  out  1  latched stuck-sensor flag; constant 0 when macro is absent
// BEHAVIOUR
//  Reset (rst=1 at posedge): sync chain=0, deb counter=0, sensor_db=0, state=IDLE,
//   car_req=0, sensor_fault=0, stuck counter=0. Reset mid-operation aborts any request.
//  Sync: sensor_raw through SYNC_STAGES flops; last stage is s_sync.
//  Debounce: counter increments each cycle s_sync != sensor_db. Clears when they agree.
//   On the DEB_CYCLES-th consecutive disagreement, sensor_db <= s_sync and the counter clears.
//   Glitches shorter than DEB_CYCLES cycles at s_sync never reach sensor_db.
//  Latency: stable raw edge -> sensor_db change after SYNC_STAGES+DEB_CYCLES posedges.
//   car_req follows one posedge later. Defaults: 6 / 7 cycles.
//  FSM (encoded from shared package; car_req is a registered Moore output):
//   IDLE  car_req=0. sensor_db=1 & farm_green=0 -> REQ. sensor_db=1 & farm_green=1 -> SERVE.
//   REQ   car_req=1, latched even if sensor_db drops (vehicle past loop). farm_green=1 -> SERVE.
//   SERVE car_req=sensor_db, letting the controller end green early when the road clears.
//         On farm_green=0: sensor_db=1 -> REQ, else -> IDLE.
//  Simultaneous events: farm_green falling and sensor_db rising in the same cycle resolve as
//   SERVE->REQ. Every state returns to IDLE only via the paths above or rst.
//  farm_green is assumed synchronous to clk; no extra synchronisation.
// CONFIGURATION
//  SENSOR_STUCK_DETECT_EN defined:
//   - Stuck counter increments while sensor_db=1 and clears when sensor_db=0.
//   - When it reaches STUCK_CYCLES, sensor_fault <= 1 (sticky until rst).
//   - While sensor_fault=1, car_req is forced 0 and the FSM is held in IDLE.
//  Macro absent: no stuck counter; sensor_fault tied 0; FSM as above unconditionally.
// STRUCTURE
//  traffic_pkg.vh (shared include): FSM state localparams (IDLE/REQ/SERVE, 2-bit),
//   light-code localparams used by the farm_green decode at the controller top,
//   default timing constants.
//  Sub-module sensor_debounce (sync chain + debounce counter; params SYNC_STAGES,
//   DEB_CYCLES; out sensor_db). Instantiated once. FSM and stuck logic stay in this module.
// TESTING (defaults, 1 cycle = 1 clk period)
//  1. rst held 3 cycles, sensor_raw=1 -> car_req=0, sensor_db=0, sensor_fault=0 throughout reset.
//  2. sensor_raw 0->1 stable, farm_green=0 -> sensor_db=1 at posedge 6, car_req=1 at posedge 7.
//  3. sensor_raw high pulses of 1, 2 and 3 cycles, separated by 5 cycles low
//     -> sensor_db and car_req remain 0.
//  4. Request latched, then sensor_raw drops for 20 cycles with farm_green=0 -> car_req stays 1;
//     farm_green=1 -> car_req falls 7 cycles after the drop was seen (SERVE follows sensor_db);
//     farm_green=0 -> IDLE.
//  5. In SERVE with sensor_db=1, farm_green falls -> next cycle state REQ, car_req=1 without gap.
//  6. SENSOR_STUCK_DETECT_EN: sensor_raw=1 for 80 cycles -> sensor_fault=1 at posedge 6+64,
//     car_req=0 the cycle after; fault holds after sensor_raw=0 until rst.

Source files
------------

// File: rtl/farm_sensor_conditioner_pkg.sv
// ============================================================================
// Module  : farm_sensor_conditioner_pkg
// Brief   : Shared FSM encoding, light codes and default timing constants.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package farm_sensor_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    // Light codes driven by the controller; farm_green is decoded from these upstream.
    localparam logic [1:0] c_LIGHT_GREEN  = 2'd0;
    localparam logic [1:0] c_LIGHT_YELLOW = 2'd1;
    localparam logic [1:0] c_LIGHT_RED    = 2'd2;

    localparam int c_SYNC_STAGES_DEF  = 2;
    localparam int c_DEB_CYCLES_DEF   = 4;
    localparam int c_STUCK_CYCLES_DEF = 64;

    // SERVE passes the live debounced level so the controller can cut green short.
    function automatic logic f_car_req(input state_t state, input logic db);
        return (state == ST_REQ) || ((state == ST_SERVE) && db);
    endfunction

endpackage

`default_nettype wire

// File: rtl/farm_sensor_conditioner_sensor_debounce.sv
// ============================================================================
// Module  : sensor_debounce
// Brief   : Multi-flop synchroniser followed by a consecutive-sample debouncer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sensor_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sensor_raw,
    output logic sensor_db
);

    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DEB_W-1:0]       r_cnt;
    logic                   r_db;
    logic                   w_s_sync;

    assign w_s_sync  = r_sync[SYNC_STAGES-1];
    assign sensor_db = r_db;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sensor_raw};
        end
    end

    // Any agreeing sample restarts the run, so short glitches never flip the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_db  <= 1'b0;
        end else if (w_s_sync != r_db) begin
            if (r_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                r_db  <= w_s_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DEB_W'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/farm_sensor_conditioner.sv
// ============================================================================
// Module  : farm_sensor_conditioner
// Brief   : Farm-road loop sensor conditioning and latched car request.
//           Optional stuck-sensor detection: define SENSOR_STUCK_DETECT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module farm_sensor_conditioner
    import farm_sensor_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES  = c_SYNC_STAGES_DEF,
    parameter int DEB_CYCLES   = c_DEB_CYCLES_DEF,
    parameter int STUCK_CYCLES = c_STUCK_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic sensor_raw,
    input  logic farm_green,
    output logic car_req,
    output logic sensor_db,
    output logic sensor_fault
);

    generate
        if ((SYNC_STAGES < 2) || (DEB_CYCLES < 1) || (STUCK_CYCLES < 1)) begin : g_bad_params
            $error("farm_sensor_conditioner: parameter out of range");
        end
    endgenerate

    logic   w_sensor_db;
    logic   w_fault;
    state_t r_state;
    state_t w_state_next;
    logic   r_car_req;
    logic   w_car_req_next;

    sensor_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYCLES  (DEB_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .sensor_raw (sensor_raw),
        .sensor_db  (w_sensor_db)
    );

    assign sensor_db = w_sensor_db;
    assign car_req   = r_car_req;

`ifdef SENSOR_STUCK_DETECT_EN
    localparam int CNT_W = $clog2(STUCK_CYCLES + 1);

    logic [CNT_W-1:0] r_stuck_cnt;
    logic             r_fault;

    // Counter saturates at the threshold; the fault flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stuck_cnt <= '0;
            r_fault     <= 1'b0;
        end else if (w_sensor_db) begin
            if (r_stuck_cnt == CNT_W'(STUCK_CYCLES - 1)) begin
                r_fault <= 1'b1;
            end
            if (r_stuck_cnt != CNT_W'(STUCK_CYCLES)) begin
                r_stuck_cnt <= r_stuck_cnt + CNT_W'(1);
            end
        end else begin
            r_stuck_cnt <= '0;
        end
    end

    assign w_fault = r_fault;
`else
    assign w_fault = 1'b0;
`endif

    assign sensor_fault = w_fault;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_sensor_db) begin
                    w_state_next = farm_green ? ST_SERVE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (farm_green) begin
                    w_state_next = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (!farm_green) begin
                    w_state_next = w_sensor_db ? ST_REQ : ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (w_fault) begin
            w_state_next = ST_IDLE;
        end
        w_car_req_next = !w_fault && f_car_req(w_state_next, w_sensor_db);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_car_req <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_car_req <= w_car_req_next;
        end
    end

endmodule

`default_nettype wire
